// File: rtl/skew_tile_buffer.sv
// Double-buffered DIM x DIM operand tile buffer that streams its tile as a diagonally skewed wavefront.
// Optional feature: define SKEW_STALL_CNT_EN to get a saturating stream-stall counter on o_stall_cnt.
module skew_tile_buffer #(
    parameter int BITS    = 8,
    parameter int DIM     = 8,
    parameter int ROWBITS = $clog2(DIM)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [ROWBITS-1:0]     i_wr_row,
    input  logic signed [BITS-1:0] i_wr_data [DIM-1:0],
    input  logic                   i_wr_commit,
    output logic                   o_wr_ready,
    input  logic                   i_col_mode,
    input  logic                   i_start,
    input  logic                   i_en,
    output logic signed [BITS-1:0] o_out [DIM-1:0],
    output logic                   o_out_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [15:0]            o_stall_cnt
);
    localparam int KW = ROWBITS + 1;
    localparam logic [KW-1:0] KLast = KW'(2 * DIM - 2);

    typedef enum logic [0:0] {StIdle, StStream} state_e;
    typedef enum logic [1:0] {BkEmpty, BkFull, BkStream} bank_e;

    state_e                 r_state;
    state_e                 w_state_d;
    bank_e                  r_bst [2];
    bank_e                  w_bst_d [2];
    logic                   r_wr_bank;
    logic                   r_rd_bank;
    logic [KW-1:0]          r_k;
    logic                   r_col_mode;
    logic [DIM-1:0]         r_row_vld [2];
    logic signed [BITS-1:0] r_mem [2][DIM-1:0][DIM-1:0];
    logic signed [BITS-1:0] r_out [DIM-1:0];
    logic                   r_out_valid;
    logic                   r_done;

    logic                   w_wr_ok;
    logic                   w_commit_ok;
    logic                   w_start_ok;
    logic                   w_adv;
    logic                   w_end;
    logic                   w_mode;
    logic [KW-1:0]          w_kn;
    logic signed [BITS-1:0] w_lane [DIM-1:0];

    assign o_wr_ready  = (r_bst[r_wr_bank] == BkEmpty);
    assign w_wr_ok     = i_wr_en & o_wr_ready;
    assign w_commit_ok = i_wr_commit & o_wr_ready;

    always_comb begin
        w_state_d  = r_state;
        w_bst_d[0] = r_bst[0];
        w_bst_d[1] = r_bst[1];
        w_start_ok = 1'b0;
        w_adv      = 1'b0;
        w_end      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start && (r_bst[r_rd_bank] == BkFull)) begin
                    w_start_ok           = 1'b1;
                    w_state_d            = StStream;
                    w_bst_d[r_rd_bank]   = BkStream;
                end
            end
            StStream: begin
                if (i_en) begin
                    if (r_k == KLast) begin
                        w_end              = 1'b1;
                        w_state_d          = StIdle;
                        w_bst_d[r_rd_bank] = BkEmpty;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
        // Commit only ever targets an EMPTY bank, so it cannot collide with the read-bank update.
        if (w_commit_ok) begin
            w_bst_d[r_wr_bank] = BkFull;
        end
    end

    // Outputs are registered, so lanes are computed for the k that becomes visible after the edge.
    assign w_kn   = w_start_ok ? '0 : r_k + KW'(1);
    assign w_mode = w_start_ok ? i_col_mode : r_col_mode;

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        logic [KW-1:0]      w_off;
        logic [ROWBITS-1:0] w_idx;
        logic [ROWBITS-1:0] w_row_sel;
        logic [ROWBITS-1:0] w_col_sel;
        logic               w_hit;

        assign w_off     = w_kn - KW'(gi);
        assign w_idx     = w_off[ROWBITS-1:0];
        assign w_hit     = (w_kn >= KW'(gi)) && (w_off < KW'(DIM));
        assign w_row_sel = w_mode ? w_idx : ROWBITS'(gi);
        assign w_col_sel = w_mode ? ROWBITS'(gi) : w_idx;
        // Rows not written since the bank was emptied read as zero via the row-valid mask.
        assign w_lane[gi] = (w_hit && r_row_vld[r_rd_bank][w_row_sel]) ?
                            r_mem[r_rd_bank][w_row_sel][w_col_sel] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            for (int c = 0; c < DIM; c++) begin
                r_mem[r_wr_bank][i_wr_row][c] <= i_wr_data[c];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_bst[0]     <= BkEmpty;
            r_bst[1]     <= BkEmpty;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_k          <= '0;
            r_col_mode   <= 1'b0;
            r_row_vld[0] <= '0;
            r_row_vld[1] <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            r_state  <= w_state_d;
            r_bst[0] <= w_bst_d[0];
            r_bst[1] <= w_bst_d[1];
            r_done   <= w_end;
            if (w_commit_ok) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_end) begin
                r_rd_bank            <= ~r_rd_bank;
                r_row_vld[r_rd_bank] <= '0;
            end
            if (w_wr_ok) begin
                r_row_vld[r_wr_bank][i_wr_row] <= 1'b1;
            end
            if (w_start_ok) begin
                r_col_mode <= i_col_mode;
            end
            if (w_start_ok || w_adv) begin
                r_k         <= w_kn;
                r_out       <= w_lane;
                r_out_valid <= 1'b1;
            end else if (w_end) begin
                r_k         <= '0;
                r_out_valid <= 1'b0;
                for (int i = 0; i < DIM; i++) begin
                    r_out[i] <= '0;
                end
            end
        end
    end

`ifdef SKEW_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_start_ok) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StStream) && !i_en && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = 16'd0;
`endif

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state == StStream);
    assign o_done      = r_done;

endmodule

// File: tb/tb_skew_tile_buffer.sv
// Self-checking bench for skew_tile_buffer (DIM=4): directed vector table, ping-pong sequence,
// and randomized traffic checked against a tile-queue reference model.
module tb_skew_tile_buffer;
    localparam int BITS = 8;
    localparam int DIM  = 4;
    localparam int W    = DIM * BITS;

    typedef logic [DIM*DIM*BITS-1:0] tile_t;

    typedef struct {
        bit          rst;
        bit          we;
        int          row;
        bit          cm;
        bit          mode;
        bit          st;
        bit          en;
        bit          e_valid;
        bit          e_done;
        bit          e_busy;
        logic [31:0] e_out;
        int          e_stall;
    } vec_t;

    logic                   clk;
    logic                   rst_n;
    logic                   wr_en;
    logic [1:0]             wr_row;
    logic signed [BITS-1:0] wr_data [DIM-1:0];
    logic                   wr_commit;
    logic                   wr_ready;
    logic                   col_mode;
    logic                   start;
    logic                   en;
    logic signed [BITS-1:0] dut_out [DIM-1:0];
    logic                   out_valid;
    logic                   busy;
    logic                   done;
    logic [15:0]            stall_cnt;
    logic [W-1:0]           got_out;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: committed tiles form a queue whose head is the tile being / next streamed.
    tile_t    m_q[$];
    tile_t    m_wbuf;
    tile_t    m_cur;
    bit       m_stream;
    int       m_k;
    bit       m_mode;
    logic [W-1:0] m_out;
    bit       m_valid;
    bit       m_done;
    int       m_stall;

    skew_tile_buffer #(.BITS(BITS), .DIM(DIM)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_row    (wr_row),
        .i_wr_data   (wr_data),
        .i_wr_commit (wr_commit),
        .o_wr_ready  (wr_ready),
        .i_col_mode  (col_mode),
        .i_start     (start),
        .i_en        (en),
        .o_out       (dut_out),
        .o_out_valid (out_valid),
        .o_busy      (busy),
        .o_done      (done),
        .o_stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        got_out = '0;
        for (int i = 0; i < DIM; i++) begin
            got_out[i*BITS +: BITS] = dut_out[i];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int stall_exp(int s);
`ifdef SKEW_STALL_CNT_EN
        return s;
`else
        return 0;
`endif
    endfunction

    function automatic logic [W-1:0] lanes_of(tile_t t, int k, bit mode);
        logic [W-1:0] res = '0;
        for (int i = 0; i < DIM; i++) begin
            int d = k - i;
            if (d >= 0 && d < DIM) begin
                res[i*BITS +: BITS] = mode ? t[(d*DIM+i)*BITS +: BITS] : t[(i*DIM+d)*BITS +: BITS];
            end
        end
        return res;
    endfunction

    function automatic vec_t mk(bit rst, bit we, int row, bit cm, bit mode, bit st, bit e,
                                bit ev, bit ed, bit eb, logic [31:0] eo, int es);
        vec_t v;
        v.rst = rst; v.we = we; v.row = row; v.cm = cm; v.mode = mode; v.st = st; v.en = e;
        v.e_valid = ev; v.e_done = ed; v.e_busy = eb; v.e_out = eo; v.e_stall = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Tile T[r][c] = 4r+c+1, optionally negated.
    task automatic load_row(input int row, input bit neg);
        for (int c = 0; c < DIM; c++) begin
            int v = 4 * row + c + 1;
            wr_data[c] = BITS'(neg ? -v : v);
        end
    endtask

    task automatic set_in(input bit r, input bit we, input int row, input bit cm, input bit mode,
                          input bit st, input bit e);
        rst_n = r; wr_en = we; wr_row = 2'(row); wr_commit = cm; col_mode = mode;
        start = st; en = e;
    endtask

    task automatic model_step();
        bit ready;
        bit endc;
        bit startc;
        if (!rst_n) begin
            m_q.delete();
            m_wbuf = '0; m_stream = 0; m_k = 0; m_mode = 0; m_out = '0;
            m_valid = 0; m_done = 0; m_stall = 0;
            return;
        end
        ready  = m_q.size() < 2;
        endc   = m_stream && en && (m_k == 2 * DIM - 2);
        startc = !m_stream && start && (m_q.size() > 0);
        m_done = endc;
        if (ready && wr_en) begin
            for (int c = 0; c < DIM; c++) begin
                m_wbuf[(int'(wr_row)*DIM + c)*BITS +: BITS] = wr_data[c];
            end
        end
        if (endc) begin
            void'(m_q.pop_front());
            m_stream = 0; m_valid = 0; m_out = '0;
        end else if (startc) begin
            m_cur = m_q[0]; m_stream = 1; m_k = 0; m_mode = col_mode; m_stall = 0;
            m_valid = 1; m_out = lanes_of(m_cur, 0, m_mode);
        end else if (m_stream && en) begin
            m_k++;
            m_out = lanes_of(m_cur, m_k, m_mode);
        end else if (m_stream && !en && m_stall < 65535) begin
            m_stall++;
        end
        if (ready && wr_commit) begin
            m_q.push_back(m_wbuf);
            m_wbuf = '0;
        end
    endtask

    task automatic step_chk(input string name);
        model_step();
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 32'(out_valid), 32'(m_valid));
        chk({name, "_done"}, 32'(done), 32'(m_done));
        chk({name, "_busy"}, 32'(busy), 32'(m_stream));
        chk({name, "_ready"}, 32'(wr_ready), 32'(m_q.size() < 2));
        chk({name, "_out"}, got_out, m_out);
        chk({name, "_stall"}, 32'(stall_cnt), 32'(stall_exp(m_stall)));
    endtask

    initial begin
        vec_t vt[$];
        int   guard;

        set_in(0, 0, 0, 0, 0, 0, 1);
        load_row(0, 0);

        // Directed table: row skew with a 3-cycle stall, column skew, mid-stream reset, empty tile.
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0));
        for (int r = 0; r < 4; r++) vt.push_back(mk(1, 1, r, r == 3, 0, 0, 1, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 32'h00000001, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h00000502, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h00090603, 0));
        for (int s = 1; s <= 3; s++) vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h00090603, s));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h0d0a0704, 3));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h0e0b0800, 3));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h0f0c0000, 3));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h10000000, 3));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 3));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 3));
        for (int r = 0; r < 4; r++) vt.push_back(mk(1, 1, r, r == 3, 0, 0, 1, 0, 0, 0, 32'h0, 3));
        vt.push_back(mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 1, 32'h00000001, 0));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 32'h00000205, 0));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 32'h00030609, 0));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 32'h04070a0d, 0));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 32'h080b0e00, 0));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 32'h0c0f0000, 0));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 32'h10000000, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 0));
        for (int r = 0; r < 4; r++) vt.push_back(mk(1, 1, r, r == 3, 0, 0, 1, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 32'h00000001, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h00000502, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h00090603, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h0d0a0704, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 32'h0, 0));
        for (int k = 1; k <= 6; k++) vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            set_in(vt[i].rst, vt[i].we, vt[i].row, vt[i].cm, vt[i].mode, vt[i].st, vt[i].en);
            load_row(vt[i].row, 0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'd1);
            chk($sformatf("vec%0d_out", i), got_out, vt[i].e_out);
            chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(stall_exp(vt[i].e_stall)));
        end

        // Ping-pong: load -T while T streams, reject a third commit, start in the done cycle.
        set_in(0, 0, 0, 0, 0, 0, 1);
        step_chk("pp_rst");
        step_chk("pp_rst");
        for (int r = 0; r < 4; r++) begin
            set_in(1, 1, r, r == 3, 0, 0, 1);
            load_row(r, 0);
            step_chk("pp_ld0");
        end
        set_in(1, 0, 0, 0, 0, 1, 1);
        step_chk("pp_start0");
        for (int r = 0; r < 4; r++) begin
            set_in(1, 1, r, r == 3, 0, 0, 1);
            load_row(r, 1);
            step_chk("pp_ld1");
        end
        chk("pp_ready_full", 32'(wr_ready), 32'd0);
        set_in(1, 1, 0, 1, 0, 0, 1);
        for (int c = 0; c < DIM; c++) wr_data[c] = 8'sh55;
        step_chk("pp_commit3");
        chk("pp_ready_still_full", 32'(wr_ready), 32'd0);
        guard = 0;
        set_in(1, 0, 0, 0, 0, 0, 1);
        while (!done && guard < 20) begin
            step_chk("pp_run0");
            guard++;
        end
        chk("pp_done0_seen", 32'(done), 32'd1);
        set_in(1, 0, 0, 0, 0, 1, 1);
        step_chk("pp_start1");
        chk("pp_neg_k0", got_out, 32'h000000ff);
        set_in(1, 0, 0, 0, 0, 0, 1);
        step_chk("pp_run1");
        chk("pp_neg_k1", got_out, 32'h0000fbfe);
        guard = 0;
        while (!done && guard < 20) begin
            step_chk("pp_run1");
            guard++;
        end
        chk("pp_done1_seen", 32'(done), 32'd1);
        set_in(1, 0, 0, 0, 0, 1, 1);
        step_chk("pp_start_empty");
        chk("pp_start_empty_ignored", 32'(out_valid), 32'd0);

        // Randomized traffic against the model.
        set_in(0, 0, 0, 0, 0, 0, 1);
        step_chk("rnd_rst");
        for (int n = 0; n < 1500; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            wr_en     = 1'($urandom_range(0, 1));
            wr_row    = 2'($urandom_range(0, 3));
            wr_commit = ($urandom_range(0, 5) == 0);
            col_mode  = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 2) == 0);
            en        = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < DIM; c++) wr_data[c] = BITS'($urandom);
            step_chk("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
